pifo_root_arbiter: RTL and testbench
====================================

// Module: pifo_root_arbiter
// PURPOSE
//  Shares the root level of the SRAM-backed PIFO tree between TREE_NUM virtual-tree requesters.
//  - Round-robin arbitration; at most one push or pop command per slot to the root PIFO_SRAM node.
//  - Honours the node's pop timing: a pop slot is followed by one blocked cycle, because the node ignores commands in its POP state.
//  - Tracks per-tree occupancy, so pops to empty trees and pushes to full trees are never issued.
// PARAMETERS
//  PTW           16                     payload/priority width; low PTW bits are the rank
//  MTW           0                      metadata width
//  CTW           10                     occupancy counter width
//  LEVEL         4                      tree depth
//  TREE_NUM      4                      number of virtual trees/requesters
//  TREE_NUM_BITS $clog2(TREE_NUM)       tree id width
//  TREE_CAP      2*((1<<LEVEL)-1)       max entries per tree (must be < 2**CTW)
// PORTS
//  i_clk            in   1                  clock
//  i_arst_n         in   1                  reset, synchronous, active-low
//  i_req_push       in   TREE_NUM           per-tree push request; held until ack
//  i_req_pop        in   TREE_NUM           per-tree pop request; held until ack
//  i_req_push_data  in   TREE_NUM*(MTW+PTW) push data; slice t belongs to tree t
//  o_req_ack        out  TREE_NUM           one-hot, combinational; a transfer happens when req & ack at the clock edge
//  o_pop_valid      out  1                  1-cycle pulse: popped data returned
//  o_pop_tree_id    out  TREE_NUM_BITS      tree id of o_pop_data
//  o_pop_data       out  MTW+PTW            popped entry
//  o_drop           out  1                  1-cycle pulse: acked push was discarded (rank all-ones)
//  o_count          out  TREE_NUM*CTW       per-tree occupancy
//  o_push           out  1                  push command to root node
//  o_push_data      out  MTW+PTW            push data to root node
//  o_pop            out  1                  pop command to root node
//  i_pop_data       in   MTW+PTW            root node pop data (valid while node is in POP)
//  o_tree_id        out  TREE_NUM_BITS      tree id for current command
//  o_my_addr        out  LEVEL              constant 0 (root address)
//  o_level          out  $clog2(LEVEL)      constant 0
// BEHAVIOUR
//  Reset (sync, i_arst_n=0 at posedge):
//   - all o_* commands/pulses are 0; o_count all 0; rr_ptr=0; FSM=ARB.
//   - An in-flight pop is discarded (no o_pop_valid).
//  Eligibility:
//   - push(t) needs count[t] < TREE_CAP; pop(t) needs count[t] != 0.
//   - If a tree asserts both and both are eligible, its pop is chosen.
//  FSM ARB:
//   - Pick the first eligible tree at or after rr_ptr (cyclic). Assert o_req_ack[t] and the command to the root combinationally, same cycle.
//   - At the edge: rr_ptr <= (t+1) % TREE_NUM.
//   - Push: count[t] += 1; stay in ARB, so back-to-back pushes are allowed.
//   - Pop: count[t] -= 1; go to HOLD; latch t.
//   - No eligible request: all commands 0; pointer unchanged.
//  FSM HOLD (cycle N+1 after a pop issued in N):
//   - No ack, no command.
//   - Capture i_pop_data and the latched t; go to ARB.
//   - o_pop_valid/o_pop_data/o_pop_tree_id are registered: pulse in N+2.
//   - The next command may issue in N+2, coinciding with the node's WB state.
//  Drop: a push whose rank is {PTW{1'b1}} (node empty sentinel) is still acked, but:
//   - no o_push and count unchanged; o_drop pulses in the next cycle.
//  Widths: counts saturate by construction and never wrap; idle o_push_data = 0.
// CONFIGURATION
//  PIFO_ARB_POP_PRIO_EN defined:
//   - Two-pass arbitration: any eligible pop (round-robin among pops) beats every push.
//  Undefined:
//   - Single round-robin over trees; pop-over-push applies within a tree only.
// STRUCTURE
//  Package pifo_pkg holds:
//   - ARB/HOLD state enum, the node state codes (IDLE 00, PUSH 01, POP 11, WB 10), and a function for the empty-rank constant.
//  Sub-module pifo_rr_arb:
//   - Parameterised N-way round-robin picker: inputs req vector and ptr; outputs one-hot grant and valid.
//   - Instantiated once; twice under PIFO_ARB_POP_PRIO_EN.
// TESTING
//  1. Tree 2 pushes rank 5 -> ack[2] and o_push in the same cycle; o_tree_id=2; count[2]=1.
//  2. Pop tree 2 in cycle N, i_pop_data=5 in N+1 -> no ack in N+1; in N+2 o_pop_valid=1, data=5, tree_id=2; count[2]=0.
//  3. All 4 trees request push continuously from reset -> acks in order 0,1,2,3,0; one per cycle.
//  4. Pop to tree 1 with count 0 -> never acked; push to a tree at TREE_CAP=30 -> never acked.
//  5. Push rank 16'hFFFF -> acked, o_push=0, o_drop pulses, count unchanged.
//  6. Reset asserted in HOLD -> next cycle: o_pop_valid=0, counts 0, rr_ptr 0; with PIFO_ARB_POP_PRIO_EN, push(0)+pop(3) pending -> pop(3) wins.

Source files
------------

// File: rtl/pifo_root_arbiter_pkg.sv
// Shared types for the PIFO root arbiter: arbiter FSM states, root node state codes
// and the empty-rank sentinel helper.
package pifo_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Root PIFO_SRAM node state encoding, kept here so node and arbiter agree.
   typedef enum logic [1:0] {
      NODE_IDLE = 2'b00,
      NODE_PUSH = 2'b01,
      NODE_POP  = 2'b11,
      NODE_WB   = 2'b10
   } node_state_t;

   function automatic logic [63:0] empty_rank(input int unsigned w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/pifo_root_arbiter_if.sv
// Requester, status and root-node command signals of the PIFO root arbiter.
interface pifo_root_arbiter_if #(
   parameter int PTW           = 16,
   parameter int MTW           = 0,
   parameter int CTW           = 10,
   parameter int LEVEL         = 4,
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) ();
   localparam int DW  = MTW + PTW;
   localparam int LVW = (LEVEL > 1) ? $clog2(LEVEL) : 1;

   logic [TREE_NUM-1:0]               req_push;
   logic [TREE_NUM-1:0]               req_pop;
   logic [TREE_NUM-1:0][DW-1:0]       req_push_data;
   logic [TREE_NUM-1:0]               req_ack;
   logic                              pop_valid;
   logic [TREE_NUM_BITS-1:0]          pop_tree_id;
   logic [DW-1:0]                     pop_data;
   logic                              drop;
   logic [TREE_NUM-1:0][CTW-1:0]      count;
   logic                              push;
   logic [DW-1:0]                     push_data;
   logic                              pop;
   logic [DW-1:0]                     node_pop_data;
   logic [TREE_NUM_BITS-1:0]          tree_id;
   logic [LEVEL-1:0]                  my_addr;
   logic [LVW-1:0]                    level;

   modport master (
      input  req_push, req_pop, req_push_data, node_pop_data,
      output req_ack, pop_valid, pop_tree_id, pop_data, drop, count,
             push, push_data, pop, tree_id, my_addr, level
   );

   modport slave (
      output req_push, req_pop, req_push_data, node_pop_data,
      input  req_ack, pop_valid, pop_tree_id, pop_data, drop, count,
             push, push_data, pop, tree_id, my_addr, level
   );
endinterface

// File: rtl/pifo_root_arbiter_rr_arb.sv
// N-way round-robin picker: first requester at or after ptr, cyclically.
module pifo_rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid,
   output logic [PW-1:0] idx
);
   always_comb begin
      int j;
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!valid && req[j]) begin
            valid    = 1'b1;
            grant[j] = 1'b1;
            idx      = PW'(j);
         end
      end
   end
endmodule

// File: rtl/pifo_root_arbiter.sv
// Root-level arbiter sharing one PIFO_SRAM node among TREE_NUM virtual trees.
// Optional PIFO_ARB_POP_PRIO_EN: any eligible pop beats every push.
module pifo_root_arbiter
   import pifo_pkg::*;
#(
   parameter int PTW           = 16,
   parameter int MTW           = 0,
   parameter int CTW           = 10,
   parameter int LEVEL         = 4,
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
   parameter int TREE_CAP      = 2 * ((1 << LEVEL) - 1)
) (
   input logic                 clk,
   input logic                 arst_n,
   pifo_root_arbiter_if.master bus
);
   localparam int DW = MTW + PTW;
   localparam int TNB = TREE_NUM_BITS;
   localparam logic [PTW-1:0] EMPTY_RANK = PTW'(empty_rank(PTW));
   localparam logic [CTW-1:0] CAP = CTW'(TREE_CAP);

   arb_state_t                   state;
   logic [TNB-1:0]               rr_ptr;
   logic [TNB-1:0]               hold_id;
   logic [TREE_NUM-1:0][CTW-1:0] cnt;
   logic                         pop_valid_q;
   logic [TNB-1:0]               pop_tree_id_q;
   logic [DW-1:0]                pop_data_q;
   logic                         drop_q;

   logic [TREE_NUM-1:0] push_ok, pop_ok;
   logic [TREE_NUM-1:0] sel_gnt;
   logic                sel_vld, sel_is_pop;
   logic [TNB-1:0]      sel_idx;

   always_comb begin
      for (int t = 0; t < TREE_NUM; t++) begin
         push_ok[t] = bus.req_push[t] && (cnt[t] < CAP);
         pop_ok[t]  = bus.req_pop[t]  && (cnt[t] != '0);
      end
   end

`ifdef PIFO_ARB_POP_PRIO_EN
   logic [TREE_NUM-1:0] pop_gnt, push_gnt;
   logic                pop_vld, push_vld;
   logic [TNB-1:0]      pop_idx, push_idx;

   pifo_rr_arb #(.N(TREE_NUM), .PW(TNB)) u_pop_arb (
      .req(pop_ok), .ptr(rr_ptr), .grant(pop_gnt), .valid(pop_vld), .idx(pop_idx)
   );
   pifo_rr_arb #(.N(TREE_NUM), .PW(TNB)) u_push_arb (
      .req(push_ok), .ptr(rr_ptr), .grant(push_gnt), .valid(push_vld), .idx(push_idx)
   );

   assign sel_vld    = pop_vld | push_vld;
   assign sel_gnt    = pop_vld ? pop_gnt : push_gnt;
   assign sel_idx    = pop_vld ? pop_idx : push_idx;
   assign sel_is_pop = pop_vld;
`else
   pifo_rr_arb #(.N(TREE_NUM), .PW(TNB)) u_arb (
      .req(push_ok | pop_ok), .ptr(rr_ptr), .grant(sel_gnt), .valid(sel_vld), .idx(sel_idx)
   );

   // A tree asking for both gets its pop; the push waits for a later slot.
   assign sel_is_pop = pop_ok[sel_idx];
`endif

   logic          active, sel_empty;
   logic [DW-1:0] sel_data;
   logic [TNB-1:0] next_ptr;

   assign active    = arst_n && (state == ARB) && sel_vld;
   assign sel_data  = bus.req_push_data[sel_idx];
   assign sel_empty = (sel_data[PTW-1:0] == EMPTY_RANK);
   assign next_ptr  = (int'(sel_idx) == TREE_NUM - 1) ? '0 : sel_idx + 1'b1;

   assign bus.req_ack   = active ? sel_gnt : '0;
   assign bus.pop       = active && sel_is_pop;
   assign bus.push      = active && !sel_is_pop && !sel_empty;
   assign bus.push_data = bus.push ? sel_data : '0;
   // During HOLD the node is reading, so keep presenting the tree it is popping.
   assign bus.tree_id   = active ? sel_idx : ((state == HOLD) ? hold_id : '0);
   assign bus.my_addr   = '0;
   assign bus.level     = '0;

   assign bus.pop_valid   = pop_valid_q;
   assign bus.pop_tree_id = pop_tree_id_q;
   assign bus.pop_data    = pop_data_q;
   assign bus.drop        = drop_q;
   assign bus.count       = cnt;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state         <= ARB;
         rr_ptr        <= '0;
         hold_id       <= '0;
         cnt           <= '0;
         pop_valid_q   <= 1'b0;
         pop_tree_id_q <= '0;
         pop_data_q    <= '0;
         drop_q        <= 1'b0;
      end else begin
         pop_valid_q <= 1'b0;
         drop_q      <= 1'b0;
         case (state)
            ARB: begin
               if (active) begin
                  rr_ptr <= next_ptr;
                  if (sel_is_pop) begin
                     cnt[sel_idx] <= cnt[sel_idx] - 1'b1;
                     hold_id      <= sel_idx;
                     state        <= HOLD;
                  end else if (sel_empty) begin
                     drop_q <= 1'b1;
                  end else begin
                     cnt[sel_idx] <= cnt[sel_idx] + 1'b1;
                  end
               end
            end
            HOLD: begin
               pop_valid_q   <= 1'b1;
               pop_data_q    <= bus.node_pop_data;
               pop_tree_id_q <= hold_id;
               state         <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end
endmodule

// File: tb/tb_pifo_root_arbiter.sv
// Directed self-checking bench for pifo_root_arbiter (4 trees, 16-bit rank, cap 30).
module tb_pifo_root_arbiter;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pifo_root_arbiter_if #(.PTW(16), .MTW(0), .CTW(10), .LEVEL(4), .TREE_NUM(4)) bus ();

   pifo_root_arbiter #(.PTW(16), .MTW(0), .CTW(10), .LEVEL(4), .TREE_NUM(4)) dut (
      .clk(clk), .arst_n(arst_n), .bus(bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.req_push      = '0;
      bus.req_pop       = '0;
      bus.req_push_data = '0;
      bus.node_pop_data = '0;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      clear_reqs();
      step();
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      clear_reqs();
      bus.req_push = 4'hF;
      bus.req_push_data[0] = 16'd1;
      step();
      step();
      #2;
      checks++;
      if (bus.req_ack !== 4'b0000 || bus.push !== 1'b0 || bus.pop !== 1'b0) begin
         failures++;
         $display("FAIL reset_cmds ack=%b push=%b pop=%b exp 0000/0/0", bus.req_ack, bus.push, bus.pop);
      end
      checks++;
      if (bus.count !== '0 || bus.pop_valid !== 1'b0 || bus.drop !== 1'b0) begin
         failures++;
         $display("FAIL reset_state count=%h pop_valid=%b drop=%b exp 0/0/0", bus.count, bus.pop_valid, bus.drop);
      end
      clear_reqs();
      arst_n = 1'b1;
      step();
   endtask

   task automatic test_push();
      bus.req_push[2] = 1'b1;
      bus.req_push_data[2] = 16'd5;
      #2;
      checks++;
      if (bus.req_ack !== 4'b0100 || bus.push !== 1'b1 || bus.tree_id !== 2'd2 || bus.push_data !== 16'd5) begin
         failures++;
         $display("FAIL push_cmd ack=%b push=%b id=%0d data=%h exp 0100/1/2/0005",
                  bus.req_ack, bus.push, bus.tree_id, bus.push_data);
      end
      step();
      clear_reqs();
      #2;
      checks++;
      if (bus.count[2] !== 10'd1 || bus.push !== 1'b0 || bus.push_data !== 16'd0) begin
         failures++;
         $display("FAIL push_count count2=%0d push=%b push_data=%h exp 1/0/0000", bus.count[2], bus.push, bus.push_data);
      end
   endtask

   task automatic test_pop();
      bus.req_pop[2] = 1'b1;
      #2;
      checks++;
      if (bus.req_ack !== 4'b0100 || bus.pop !== 1'b1 || bus.tree_id !== 2'd2) begin
         failures++;
         $display("FAIL pop_cmd ack=%b pop=%b id=%0d exp 0100/1/2", bus.req_ack, bus.pop, bus.tree_id);
      end
      step();
      clear_reqs();
      bus.node_pop_data = 16'd5;
      bus.req_push[0] = 1'b1;
      bus.req_push_data[0] = 16'd9;
      #2;
      checks++;
      if (bus.req_ack !== 4'b0000 || bus.pop !== 1'b0 || bus.push !== 1'b0) begin
         failures++;
         $display("FAIL pop_hold ack=%b pop=%b push=%b exp 0000/0/0", bus.req_ack, bus.pop, bus.push);
      end
      step();
      bus.node_pop_data = 16'd0;
      #2;
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'd5 || bus.pop_tree_id !== 2'd2 || bus.count[2] !== 10'd0) begin
         failures++;
         $display("FAIL pop_result valid=%b data=%h id=%0d count2=%0d exp 1/0005/2/0",
                  bus.pop_valid, bus.pop_data, bus.pop_tree_id, bus.count[2]);
      end
      checks++;
      if (bus.req_ack !== 4'b0001) begin
         failures++;
         $display("FAIL pop_next_slot ack=%b exp 0001", bus.req_ack);
      end
      bus.req_push = '0;
      step();
      checks++;
      if (bus.pop_valid !== 1'b0 || bus.count[0] !== 10'd0) begin
         failures++;
         $display("FAIL pop_pulse_end valid=%b count0=%0d exp 0/0", bus.pop_valid, bus.count[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      do_reset();
      bus.req_push = 4'hF;
      for (int t = 0; t < 4; t++) bus.req_push_data[t] = 16'(t + 1);
      for (int i = 0; i < 5; i++) begin
         exp = 4'(1 << (i % 4));
         #2;
         checks++;
         if (bus.req_ack !== exp || bus.push !== 1'b1) begin
            failures++;
            $display("FAIL rr_order[%0d] ack=%b push=%b exp %b/1", i, bus.req_ack, bus.push, exp);
         end
         step();
      end
      clear_reqs();
      #2;
      checks++;
      if (bus.count[0] !== 10'd2 || bus.count[1] !== 10'd1 || bus.count[2] !== 10'd1 || bus.count[3] !== 10'd1) begin
         failures++;
         $display("FAIL rr_counts got=%0d,%0d,%0d,%0d exp 2,1,1,1", bus.count[0], bus.count[1], bus.count[2], bus.count[3]);
      end
   endtask

   task automatic test_ineligible();
      do_reset();
      bus.req_pop[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++;
         if (bus.req_ack !== 4'b0000 || bus.pop !== 1'b0) begin
            failures++;
            $display("FAIL pop_empty[%0d] ack=%b pop=%b exp 0000/0", i, bus.req_ack, bus.pop);
         end
         step();
      end
      clear_reqs();
      bus.req_push[3] = 1'b1;
      bus.req_push_data[3] = 16'd7;
      for (int i = 0; i < 30; i++) step();
      #2;
      checks++;
      if (bus.count[3] !== 10'd30 || bus.req_ack !== 4'b0000 || bus.push !== 1'b0) begin
         failures++;
         $display("FAIL push_full count3=%0d ack=%b push=%b exp 30/0000/0", bus.count[3], bus.req_ack, bus.push);
      end
      step();
      checks++;
      if (bus.count[3] !== 10'd30 || bus.req_ack !== 4'b0000) begin
         failures++;
         $display("FAIL push_full_hold count3=%0d ack=%b exp 30/0000", bus.count[3], bus.req_ack);
      end
      bus.req_pop[3] = 1'b1;
      #2;
      checks++;
      if (bus.req_ack !== 4'b1000 || bus.pop !== 1'b1 || bus.push !== 1'b0) begin
         failures++;
         $display("FAIL pop_over_push ack=%b pop=%b push=%b exp 1000/1/0", bus.req_ack, bus.pop, bus.push);
      end
      step();
      clear_reqs();
      step();
      checks++;
      if (bus.count[3] !== 10'd29 || bus.pop_valid !== 1'b1 || bus.pop_tree_id !== 2'd3) begin
         failures++;
         $display("FAIL full_pop count3=%0d valid=%b id=%0d exp 29/1/3", bus.count[3], bus.pop_valid, bus.pop_tree_id);
      end
   endtask

   task automatic test_drop();
      do_reset();
      bus.req_push[1] = 1'b1;
      bus.req_push_data[1] = 16'hFFFF;
      #2;
      checks++;
      if (bus.req_ack !== 4'b0010 || bus.push !== 1'b0 || bus.drop !== 1'b0) begin
         failures++;
         $display("FAIL drop_ack ack=%b push=%b drop=%b exp 0010/0/0", bus.req_ack, bus.push, bus.drop);
      end
      step();
      clear_reqs();
      #2;
      checks++;
      if (bus.drop !== 1'b1 || bus.count[1] !== 10'd0) begin
         failures++;
         $display("FAIL drop_pulse drop=%b count1=%0d exp 1/0", bus.drop, bus.count[1]);
      end
      step();
      checks++;
      if (bus.drop !== 1'b0) begin
         failures++;
         $display("FAIL drop_end drop=%b exp 0", bus.drop);
      end
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      bus.req_push[0] = 1'b1;
      bus.req_push_data[0] = 16'd3;
      step();
      clear_reqs();
      bus.req_pop[0] = 1'b1;
      step();
      clear_reqs();
      bus.node_pop_data = 16'h00AB;
      arst_n = 1'b0;
      step();
      #2;
      checks++;
      if (bus.pop_valid !== 1'b0 || bus.count !== '0) begin
         failures++;
         $display("FAIL hold_reset valid=%b count=%h exp 0/0", bus.pop_valid, bus.count);
      end
      arst_n = 1'b1;
      bus.node_pop_data = '0;
      bus.req_push = 4'hF;
      for (int t = 0; t < 4; t++) bus.req_push_data[t] = 16'd2;
      #2;
      checks++;
      if (bus.req_ack !== 4'b0001) begin
         failures++;
         $display("FAIL hold_reset_ptr ack=%b exp 0001", bus.req_ack);
      end
      clear_reqs();
      step();
   endtask

   task automatic test_pop_prio();
      logic [3:0] exp;
`ifdef PIFO_ARB_POP_PRIO_EN
      exp = 4'b1000;
`else
      exp = 4'b0001;
`endif
      do_reset();
      bus.req_push[3] = 1'b1;
      bus.req_push_data[3] = 16'd9;
      step();
      clear_reqs();
      bus.req_push[0] = 1'b1;
      bus.req_push_data[0] = 16'd4;
      bus.req_pop[3] = 1'b1;
      #2;
      checks++;
      if (bus.req_ack !== exp) begin
         failures++;
         $display("FAIL pop_prio ack=%b exp %b", bus.req_ack, exp);
      end
      step();
      clear_reqs();
      step();
      step();
   endtask

   initial begin
      clear_reqs();
      test_reset();
      test_push();
      test_pop();
      test_back_to_back();
      test_ineligible();
      test_drop();
      test_reset_in_hold();
      test_pop_prio();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
